pseudo_spi_rx_intf: RTL and testbench

- Receive-direction counterpart of the pseudo-SPI SRAM-readout interface.
- Drives a two-phase shift clock (SCLK1/SCLK2) and a latch strobe into an external scan chain.
- Deserialises SPI_SI LSB-first into bytes and writes DATA_LEN consecutive bytes into the RA1SHD SRAM, starting at ADDR_BGN.
- Sits beside SRAM_IO_CTRL and the readout interface; the top level muxes SRAM A/CEN/WEN using spi_MUX.

---
 rtl/pseudo_spi_rx_intf_pkg.sv | 25 ++
 rtl/pseudo_spi_rx_intf_phase_gen.sv | 62 ++++++
 rtl/pseudo_spi_rx_intf.sv | 155 +++++++++++++++
 tb/tb_pseudo_spi_rx_intf.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_spi_rx_intf_pkg.sv
// Shared state encoding and small decode helpers for the pseudo-SPI receive
// interface and its phase generator.
package pseudo_spi_rx_intf_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LATCH = 3'b001,
    SAMP  = 3'b011,
    CLK1  = 3'b010,
    CLK2  = 3'b110,
    WRIT  = 3'b100,
    LOOP  = 3'b111,
    DONE  = 3'b101
  } rx_state_e;

  // States whose length is set by the phase generator (stretched by the divider).
  function automatic logic is_phase_state(input rx_state_e s);
    return (s == LATCH) || (s == CLK1) || (s == CLK2);
  endfunction

  function automatic logic owns_sram(input rx_state_e s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/pseudo_spi_rx_intf_phase_gen.sv
// SCLK1/SCLK2/LAT phase sequencer. With PSEUDO_SPI_RX_FREQ_DIV_EN defined, an
// 8-bit divider stretches each phase to FREQ_DIV+1 cycles before o_step.
module pseudo_spi_phase_gen
  import pseudo_spi_rx_intf_pkg::*;
(
  input  logic       CLK,
  input  logic       rst_n,
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
  input  logic [2:0] i_state,
  input  logic [7:0] i_freq_div,
`endif
  input  logic [2:0] i_next_state,
  output logic       o_step,
  output logic       o_sclk1,
  output logic       o_sclk2,
  output logic       o_lat
);

  logic r_sclk1;
  logic r_sclk2;
  logic r_lat;

  // Strobes are decoded from the next state so they line up with the state
  // register while still coming straight from flops.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk1 <= 1'b0;
      r_sclk2 <= 1'b0;
      r_lat   <= 1'b0;
    end else begin
      r_sclk1 <= (i_next_state == CLK1);
      r_sclk2 <= (i_next_state == CLK2);
      r_lat   <= (i_next_state == LATCH);
    end
  end

`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
  logic [7:0] r_div_cnt;
  logic       w_in_phase;

  assign w_in_phase = is_phase_state(rx_state_e'(i_state));
  // >= rather than == so a FREQ_DIV lowered mid-phase cannot stall the sequencer.
  assign o_step     = (r_div_cnt >= i_freq_div);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (!w_in_phase || o_step) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end
`else
  assign o_step = 1'b1;
`endif

  assign o_sclk1 = r_sclk1;
  assign o_sclk2 = r_sclk2;
  assign o_lat   = r_lat;

endmodule

// File: rtl/pseudo_spi_rx_intf.sv
// Pseudo-SPI receive interface: shifts bytes LSB-first out of an external scan
// chain and writes them to SRAM. Optional divider: PSEUDO_SPI_RX_FREQ_DIV_EN.
module pseudo_spi_rx_intf
  import pseudo_spi_rx_intf_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 10,
  parameter int RESERVED_DATA_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SPI_SI,
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
  input  logic [7:0]                   FREQ_DIV,
`endif
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         LAT,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO,
  output logic                         spi_MUX,
  output logic                         spi_is_done
);

  localparam int BIT_CNT_W = (MEMORY_DATA_WIDTH > 1) ? $clog2(MEMORY_DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0]         LAST_BIT = BIT_CNT_W'(MEMORY_DATA_WIDTH - 1);
  localparam logic [RESERVED_DATA_LEN-1:0] LEN_ONE  = RESERVED_DATA_LEN'(1);

  rx_state_e                    r_state;
  rx_state_e                    w_next_state;
  logic                         w_step;
  logic                         w_write_next;
  logic [MEMORY_ADDR_WIDTH-1:0] r_addr;
  logic [RESERVED_DATA_LEN-1:0] r_remaining;
  logic [BIT_CNT_W-1:0]         r_bit_cnt;
  logic [MEMORY_DATA_WIDTH-1:0] r_shreg;
  logic [MEMORY_DATA_WIDTH-1:0] w_shreg_next;
  logic                         r_cen;
  logic                         r_wen;
  logic [MEMORY_ADDR_WIDTH-1:0] r_a;
  logic [MEMORY_DATA_WIDTH-1:0] r_po;
  logic                         r_mux;
  logic                         r_done;

  pseudo_spi_phase_gen u_phase_gen (
    .CLK          (CLK),
    .rst_n        (rst_n),
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    .i_state      (r_state),
    .i_freq_div   (FREQ_DIV),
`endif
    .i_next_state (w_next_state),
    .o_step       (w_step),
    .o_sclk1      (SCLK1),
    .o_sclk2      (SCLK2),
    .o_lat        (LAT)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: w_next_state gets its default before any branch; a path that left it
  // unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    if ((r_state != IDLE) && !BGN) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (BGN) w_next_state = (DATA_LEN == '0) ? DONE : LATCH;
        LATCH:   if (w_step) w_next_state = SAMP;
        SAMP:    w_next_state = (r_bit_cnt == LAST_BIT) ? WRIT : CLK1;
        CLK1:    if (w_step) w_next_state = CLK2;
        CLK2:    if (w_step) w_next_state = SAMP;
        WRIT:    w_next_state = LOOP;
        LOOP:    w_next_state = (r_remaining == LEN_ONE) ? DONE : CLK1;
        DONE:    w_next_state = DONE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  assign w_shreg_next = {SPI_SI, r_shreg[MEMORY_DATA_WIDTH-1:1]};
  assign w_write_next = (w_next_state == WRIT);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          if (BGN) begin
            r_addr      <= ADDR_BGN;
            r_remaining <= DATA_LEN;
          end
        end
        SAMP: begin
          r_shreg   <= w_shreg_next;
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        LOOP: begin
          if (r_remaining != LEN_ONE) begin
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            r_bit_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // PO takes the post-shift value, since the last bit lands on the same edge
  // that enters WRIT.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_cen  <= 1'b1;
      r_wen  <= 1'b1;
      r_a    <= '0;
      r_po   <= '0;
      r_mux  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cen  <= !w_write_next;
      r_wen  <= !w_write_next;
      r_mux  <= owns_sram(w_next_state);
      r_done <= (w_next_state == DONE);
      if (w_write_next) begin
        r_a  <= r_addr;
        r_po <= w_shreg_next;
      end
    end
  end

  assign CEN         = r_cen;
  assign WEN         = r_wen;
  assign A           = r_a;
  assign PO          = r_po;
  assign spi_MUX     = r_mux;
  assign spi_is_done = r_done;

endmodule

// File: tb/tb_pseudo_spi_rx_intf.sv
// Directed bench for pseudo_spi_rx_intf: scan-chain and SRAM models, with
// hand-computed expected bytes, pulse counts and write timing.
`timescale 1ns/1ps
module tb_pseudo_spi_rx_intf;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bgn;
  logic [AW-1:0] addr_bgn;
  logic [LW-1:0] data_len;
  logic          spi_si;
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
  logic [7:0]    freq_div;
`endif
  logic          sclk1, sclk2, lat, cen, wen, spi_mux, spi_is_done;
  logic [AW-1:0] a;
  logic [DW-1:0] po;

  always #5 clk = ~clk;

  pseudo_spi_rx_intf #(
    .MEMORY_DATA_WIDTH (DW),
    .MEMORY_ADDR_WIDTH (AW),
    .RESERVED_DATA_LEN (LW)
  ) dut (
    .CLK         (clk),
    .rst_n       (rst_n),
    .BGN         (bgn),
    .ADDR_BGN    (addr_bgn),
    .DATA_LEN    (data_len),
    .SPI_SI      (spi_si),
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    .FREQ_DIV    (freq_div),
`endif
    .SCLK1       (sclk1),
    .SCLK2       (sclk2),
    .LAT         (lat),
    .CEN         (cen),
    .WEN         (wen),
    .A           (a),
    .PO          (po),
    .spi_MUX     (spi_mux),
    .spi_is_done (spi_is_done)
  );

  // Scan chain: byte k sits at bits [8k+7:8k], bit 0 presented first.
  logic [127:0] scan_img = '0;
  logic [127:0] chain = '0;
  logic [7:0]   mem [0:1023];
  logic         sclk1_q = 1'b0, sclk2_q = 1'b0, lat_q = 1'b0;
  int cyc = 0, sclk1_pulses = 0, sclk2_pulses = 0, lat_pulses = 0, lat_cyc = 0;
  int wr_cnt = 0, overlap_cnt = 0, strobe_split = 0, done_cycles = 0, cen_low = 0, mux_bad = 0;
  int run1 = 0, run2 = 0, runl = 0, max1 = 0, max2 = 0, maxl = 0;
  int wr_cyc [64];
  int wr_sclk [64];

  assign spi_si = chain[0];

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    sclk1_q <= sclk1;
    sclk2_q <= sclk2;
    lat_q   <= lat;
    if (sclk1 && !sclk1_q) sclk1_pulses <= sclk1_pulses + 1;
    if (sclk2 && !sclk2_q) sclk2_pulses <= sclk2_pulses + 1;
    if (lat && !lat_q) begin
      lat_pulses <= lat_pulses + 1;
      lat_cyc    <= cyc;
    end
    if (lat) chain <= scan_img;
    else if (sclk2 && !sclk2_q) chain <= chain >> 1;
    if (sclk1) begin run1 <= run1 + 1; if (run1 + 1 > max1) max1 <= run1 + 1; end else run1 <= 0;
    if (sclk2) begin run2 <= run2 + 1; if (run2 + 1 > max2) max2 <= run2 + 1; end else run2 <= 0;
    if (lat)   begin runl <= runl + 1; if (runl + 1 > maxl) maxl <= runl + 1; end else runl <= 0;
    if (sclk1 && sclk2) overlap_cnt <= overlap_cnt + 1;
    if (cen != wen) strobe_split <= strobe_split + 1;
    if (spi_is_done) done_cycles <= done_cycles + 1;
    if (!cen) cen_low <= cen_low + 1;
    if (!cen && !wen) begin
      mem[a] <= po;
      if (!spi_mux) mux_bad <= mux_bad + 1;
      if (wr_cnt < 64) begin
        wr_cyc[wr_cnt]  <= cyc;
        wr_sclk[wr_cnt] <= sclk1_pulses;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [AW-1:0] adr, input logic [LW-1:0] len,
                           input logic [127:0] img);
    addr_bgn = adr;
    data_len = len;
    scan_img = img;
    bgn      = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!spi_is_done && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_done"}, spi_is_done, 1'b1);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int n = 0;
    while (wr_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check(tag, wr_cnt >= target, 1'b1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_sclk1"}, sclk1, 1'b0);
    check({pfx, "_sclk2"}, sclk2, 1'b0);
    check({pfx, "_lat"},   lat,   1'b0);
    check({pfx, "_cen"},   cen,   1'b1);
    check({pfx, "_wen"},   wen,   1'b1);
    check({pfx, "_a"},     a,     '0);
    check({pfx, "_po"},    po,    '0);
    check({pfx, "_mux"},   spi_mux, 1'b0);
    check({pfx, "_done"},  spi_is_done, 1'b0);
  endtask

  logic [7:0]   t1_bytes [14] = '{8'hAB, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h80, 8'hFF,
                                  8'h55, 8'hAA, 8'h12, 8'h34, 8'hC3, 8'h7E, 8'h5A};
  logic [127:0] img;
  int w0, s0, s2, l0, d0, c0;

  initial begin
    rst_n    = 1'b0;
    bgn      = 1'b0;
    addr_bgn = '0;
    data_len = '0;
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    freq_div = 8'd0;
`endif
    step(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step(2);

    // Fourteen-byte transfer into SRAM[32..45].
    img = '0;
    for (int i = 0; i < 14; i++) img[8*i +: 8] = t1_bytes[i];
    w0 = wr_cnt; s0 = sclk1_pulses; s2 = sclk2_pulses; l0 = lat_pulses;
    start_run(10'd32, 8'd14, img);
    wait_done("t1", 1000);
    check("t1_mux_in_done", spi_mux, 1'b0);
    check("t1_writes", wr_cnt - w0, 14);
    for (int i = 0; i < 14; i++)
      check($sformatf("t1_mem_%0d", 32 + i), mem[32 + i], t1_bytes[i]);
    check("t1_lat_pulses", lat_pulses - l0, 1);
    check("t1_sclk1_total", sclk1_pulses - s0, 111);
    check("t1_sclk2_total", sclk2_pulses - s2, 111);
    check("t1_sclk1_before_first", wr_sclk[w0] - s0, 7);
    for (int i = 1; i < 14; i++)
      check($sformatf("t1_sclk1_byte_%0d", i), wr_sclk[w0 + i] - wr_sclk[w0 + i - 1], 8);
    check("t1_first_write_cycle", wr_cyc[w0] - lat_cyc, 23);
    for (int i = 1; i < 14; i++)
      check($sformatf("t1_write_gap_%0d", i), wr_cyc[w0 + i] - wr_cyc[w0 + i - 1], 26);
    check("t1_no_overlap", overlap_cnt, 0);
    check("t1_cen_wen_paired", strobe_split, 0);
    check("t1_mux_during_write", mux_bad, 0);
    check("t1_sclk1_width", max1, 1);
    check("t1_sclk2_width", max2, 1);
    step(3);
    check("t1_done_held", spi_is_done, 1'b1);
    bgn = 1'b0;
    step(1);
    check("t1_done_cleared", spi_is_done, 1'b0);
    step(2);

    // Zero-length request goes straight to DONE with no SRAM or chain activity.
    w0 = wr_cnt; s0 = sclk1_pulses; s2 = sclk2_pulses; l0 = lat_pulses; c0 = cen_low;
    start_run(10'd5, 8'd0, '0);
    wait_done("t2", 2);
    check("t2_mux", spi_mux, 1'b0);
    step(5);
    check("t2_done_held", spi_is_done, 1'b1);
    check("t2_cen_never_low", cen_low - c0, 0);
    check("t2_writes", wr_cnt - w0, 0);
    check("t2_sclk1", sclk1_pulses - s0, 0);
    check("t2_sclk2", sclk2_pulses - s2, 0);
    check("t2_lat", lat_pulses - l0, 0);
    bgn = 1'b0;
    step(2);

    // Address wraps from 1023 to 0.
    w0 = wr_cnt;
    start_run(10'd1023, 8'd2, 128'hC35A);
    wait_done("t3", 200);
    check("t3_mem_1023", mem[1023], 8'h5A);
    check("t3_mem_0", mem[0], 8'hC3);
    check("t3_writes", wr_cnt - w0, 2);
    bgn = 1'b0;
    step(2);

    // BGN dropped mid second byte: only the first byte lands, no done.
    w0 = wr_cnt; d0 = done_cycles;
    start_run(10'd100, 8'd3, 128'h332211);
    wait_writes("t4_first_write", w0 + 1, 100);
    step(9);
    bgn = 1'b0;
    step(1);
    check("t4_mux_released", spi_mux, 1'b0);
    check("t4_sclk1_idle", sclk1, 1'b0);
    s0 = sclk1_pulses;
    step(60);
    check("t4_no_more_shift", sclk1_pulses - s0, 0);
    check("t4_writes", wr_cnt - w0, 1);
    check("t4_mem_100", mem[100], 8'h11);
    check("t4_no_done", done_cycles - d0, 0);
    step(2);

    // Asynchronous reset mid-shift, then a clean rerun.
    w0 = wr_cnt;
    start_run(10'd200, 8'd2, 128'h6996);
    step(15);
    check("t5_mux_before_reset", spi_mux, 1'b1);
    #2;
    rst_n = 1'b0;
    bgn   = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    step(2);
    check("t5_no_write_in_reset", wr_cnt - w0, 0);
    rst_n = 1'b1;
    step(2);
    start_run(10'd200, 8'd2, 128'h6996);
    wait_done("t5", 200);
    check("t5_mem_200", mem[200], 8'h96);
    check("t5_mem_201", mem[201], 8'h69);
    check("t5_writes", wr_cnt - w0, 2);
    bgn = 1'b0;
    step(2);

`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
    // Divided phases: each SCLK1/SCLK2/LAT high for three cycles.
    w0 = wr_cnt;
    freq_div = 8'd2;
    start_run(10'd300, 8'd2, 128'h1EE1);
    wait_done("t6", 400);
    check("t6_mem_300", mem[300], 8'hE1);
    check("t6_mem_301", mem[301], 8'h1E);
    check("t6_writes", wr_cnt - w0, 2);
    check("t6_sclk1_width", max1, 3);
    check("t6_sclk2_width", max2, 3);
    check("t6_lat_width", maxl, 3);
    check("t6_no_overlap", overlap_cnt, 0);
    bgn = 1'b0;
    step(2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
